serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial subtractor, the subtract-side companion to the combinational adder. It computes A - B - bin over WIDTH clock cycles using a single full-subtractor cell and a stored borrow. It has a start/busy/done handshake and is intended for area-constrained datapaths where one bit-cell is reused each cycle.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous reset, active-high
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  minuend; latched when start is accepted
b      input   WIDTH  subtrahend; latched when start is accepted
bin    input   1      borrow-in; latched when start is accepted
busy   output  1      high while state is RUN
done   output  1      one-cycle pulse; results valid from this cycle on
diff   output  WIDTH  a - b - bin, modulo 2^WIDTH
bout   output  1      final borrow-out (unsigned a < b + bin)
ovf    output  1      two's-complement overflow of the subtraction

Behaviour:
- Reset: the following take effect asynchronously, with no clock needed.
  - state=IDLE, busy=0, done=0.
  - diff=0, bout=0, ovf=0.
  - Shift registers, borrow register and bit counter all go to 0.
- States: IDLE, RUN, DONE.
- IDLE, or DONE with start=1 (edge E0):
  - Latch a and b into shift registers sa and sb.
  - Load the borrow register br with bin.
  - Capture a[WIDTH-1] and b[WIDTH-1] as the sign bits.
  - Set cnt=0 and go to RUN.
- RUN, at each edge E1..E_WIDTH, process the LSB of sa and sb:
  - d = sa0 ^ sb0 ^ br.
  - br_next = (~sa0 & sb0) | (~(sa0 ^ sb0) & br).
  - Shift sa and sb right by 1.
  - Shift d into the MSB of the result shift register.
  - cnt increments.
- On the edge that processes bit WIDTH-1 (cnt == WIDTH-1):
  - diff is loaded from the completed result register.
  - bout = br_next.
  - ovf = (signA != signB) & (d != signA).
  - Go to DONE.
- DONE lasts one cycle with done=1. Without start, the next state is IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH edges after the start edge. Back-to-back operation gives a throughput of one result per WIDTH+1 cycles.
- busy is 1 exactly in RUN. done and busy are never high together.
- start while in RUN is ignored, with no effect on operands or timing.
- diff, bout and ovf change only on the completion edge. They hold their values through IDLE and through the next RUN until that run completes.
- Operand inputs are don't-care except on the accepting edge.
- Reset asserted mid-RUN aborts the operation. Outputs return to their reset values, and a partial result is never published.
- cnt width is clog2(WIDTH). There is no wrap past WIDTH-1.

Optional Feature:
Macro SERIAL_SUB_CMP_EN.
- Defined: adds outputs lt (1), eq (1) and gt (1), valid from the completion edge and held like diff.
  - lt = bout.
  - eq = (diff == 0) & ~bout.
  - gt = ~lt & ~eq.
  - All three reset to 0.
  - These are unsigned comparisons of a versus b + bin.
- Not defined: the ports and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - the state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - the counter-width helper function.
- Sub-module f_subtractor is the combinational full-subtractor cell, with ports a, b, bin, diff and bout. It is built structurally from xor/and/or/not primitives and instantiated once.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0; done high exactly 8 edges after the start edge; busy high for 8 cycles.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0; with SERIAL_SUB_CMP_EN, lt=1, eq=0, gt=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- Pulse start again at cycles 2 and 5 of RUN with different operands -> ignored, and the first result is unchanged. Hold start high during DONE -> a new operation starts with no IDLE cycle.
- Assert rst for 1 cycle at RUN cycle 4 -> busy=0 and diff=0 immediately, no done pulse follows, and the next start completes normally.
- WIDTH=4: exhaustive sweep of a, b and bin (512 cases) against a behavioural model -> diff, bout and ovf all match.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Bit-counter width; never below one bit so WIDTH=2 still gets a real register.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/f_subtractor.sv
// Combinational full-subtractor cell (a - b - bin), gate-level.
module f_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic t, na, nt, gen, prop;

  xor x_t    (t, a, b);
  xor x_diff (diff, t, bin);
  not n_a    (na, a);
  not n_t    (nt, t);
  and a_gen  (gen, na, b);
  and a_prop (prop, nt, bin);
  or  o_bout (bout, gen, prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles with start/busy/done handshake.
// Optional compare outputs lt/eq/gt when SERIAL_SUB_CMP_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
`ifdef SERIAL_SUB_CMP_EN
  ,
  output logic             lt,
  output logic             eq,
  output logic             gt
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, sgna_q, sgna_d, sgnb_q, sgnb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;
  logic             cell_diff, cell_bout;
  logic [WIDTH-1:0] res_full;

  f_subtractor u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign res_full = {cell_diff, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    sgna_d  = sgna_q;
    sgnb_d  = sgnb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          sgna_d  = a[WIDTH-1];
          sgnb_d  = b[WIDTH-1];
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = res_full;
        br_d  = cell_bout;
        cnt_d = cnt_q + 1'b1;
        // Final bit: publish straight from the cell so the result appears on this edge.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          diff_d  = res_full;
          bout_d  = cell_bout;
          ovf_d   = (sgna_q != sgnb_q) & (cell_diff != sgna_q);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sgna_q  <= 1'b0;
      sgnb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      sgna_q  <= sgna_d;
      sgnb_q  <= sgnb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

`ifdef SERIAL_SUB_CMP_EN
  logic lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  always_comb begin
    lt_d = lt_q;
    eq_d = eq_q;
    gt_d = gt_q;
    if (state_q == S_RUN && cnt_q == CNT_LAST) begin
      lt_d = cell_bout;
      eq_d = (res_full == '0) & ~cell_bout;
      gt_d = ~cell_bout & ~((res_full == '0) & ~cell_bout);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      lt_q <= lt_d;
      eq_q <= eq_d;
      gt_q <= gt_d;
    end
  end

  assign lt = lt_q;
  assign eq = eq_q;
  assign gt = gt_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 vectors) plus a WIDTH=4 exhaustive sweep.
// Checks lt/eq/gt too when SERIAL_SUB_CMP_EN is defined.
module tb_serial_subtractor;

  logic       clk, rst;
  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4, ovf4;
  logic [3:0] a4, b4, diff4;
  int         total, bad;
`ifdef SERIAL_SUB_CMP_EN
  logic       lt8, eq8, gt8, lt4, eq4, gt4;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
`ifdef SERIAL_SUB_CMP_EN
    , .lt(lt8), .eq(eq8), .gt(gt8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
`ifdef SERIAL_SUB_CMP_EN
    , .lt(lt4), .eq(eq4), .gt(gt4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of RUN cycle 1.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'hxx; b8 = 8'hxx; bin8 = 1'bx;
    chk("busy_after_start", {31'd0, busy8}, 32'd1);
    chk("no_done_in_run", {31'd0, done8}, 32'd0);
  endtask

  // Walks the run to the done cycle, optionally pulsing start at RUN cycles 2 and 5.
  task automatic wait_done(input string tag, input logic [7:0] ed, input logic eb, input logic eo,
                           input logic [7:0] prev, input logic poke);
    int cyc = 1;
    int bcnt = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) bcnt++;
      if (cyc == 4) chk({tag, "_hold"}, {24'd0, diff8}, {24'd0, prev});
      if (poke && (cyc == 2 || cyc == 5)) begin
        start8 = 1'b1; a8 = 8'hFF ^ 8'(cyc); b8 = 8'h00; bin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    chk({tag, "_latency"}, cyc - 1, 32'd8);
    chk({tag, "_busycycles"}, bcnt, 32'd8);
    chk({tag, "_busy_at_done"}, {31'd0, busy8}, 32'd0);
    chk({tag, "_diff"}, {24'd0, diff8}, {24'd0, ed});
    chk({tag, "_bout"}, {31'd0, bout8}, {31'd0, eb});
    chk({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
`ifdef SERIAL_SUB_CMP_EN
    chk({tag, "_lt"}, {31'd0, lt8}, {31'd0, eb});
    chk({tag, "_eq"}, {31'd0, eq8}, {31'd0, (ed == 8'h00) && !eb});
    chk({tag, "_gt"}, {31'd0, gt8}, {31'd0, (ed != 8'h00) && !eb});
`endif
  endtask

  task automatic op4(input int unsigned av, input int unsigned bv, input int unsigned bi);
    int n = 0;
    int sa, sb, s;
    logic [3:0] ed;
    logic eb, eo;
    a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(bi); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ed = 4'(av - bv - bi);
    eb = (av < bv + bi);
    sa = (av >= 8) ? int'(av) - 16 : int'(av);
    sb = (bv >= 8) ? int'(bv) - 16 : int'(bv);
    s  = sa - sb - int'(bi);
    eo = (s < -8) || (s > 7);
    chk($sformatf("w4_diff_%0h_%0h_%0d", av, bv, bi), {28'd0, diff4}, {28'd0, ed});
    chk($sformatf("w4_bout_%0h_%0h_%0d", av, bv, bi), {31'd0, bout4}, {31'd0, eb});
    chk($sformatf("w4_ovf_%0h_%0h_%0d", av, bv, bi), {31'd0, ovf4}, {31'd0, eo});
  endtask

  initial begin
    bit seen;
    total = 0; bad = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_diff", {24'd0, diff8}, 32'd0);
    chk("rst_bout", {31'd0, bout8}, 32'd0);
    chk("rst_ovf", {31'd0, ovf8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_op(8'h05, 8'h03, 1'b0); wait_done("v05m03", 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("idle_after_done", {30'd0, done8, busy8}, 32'd0);
    chk("idle_diff_hold", {24'd0, diff8}, 32'h02);

    start_op(8'h03, 8'h05, 1'b0); wait_done("v03m05", 8'hFE, 1'b1, 1'b0, 8'h02, 1'b0);
    @(negedge clk);
    start_op(8'h80, 8'h01, 1'b0); wait_done("v80m01", 8'h7F, 1'b0, 1'b1, 8'hFE, 1'b0);
    @(negedge clk);
    start_op(8'h00, 8'h00, 1'b1); wait_done("v00m00b", 8'hFF, 1'b1, 1'b0, 8'h7F, 1'b0);
    @(negedge clk);
    start_op(8'h33, 8'h33, 1'b0); wait_done("v33m33", 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    start_op(8'h40, 8'h11, 1'b0); wait_done("ignore_start", 8'h2F, 1'b0, 1'b0, 8'h00, 1'b1);

    // start held high in DONE: straight back into RUN
    start_op(8'h7F, 8'hFF, 1'b0); wait_done("b2b", 8'h80, 1'b1, 1'b1, 8'h2F, 1'b0);
    @(negedge clk);

    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_diff", {24'd0, diff8}, 32'd0);
    chk("abort_bout", {31'd0, bout8}, 32'd0);
    chk("abort_ovf", {31'd0, ovf8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    start_op(8'h9A, 8'h45, 1'b1); wait_done("after_abort", 8'h54, 1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);

    for (int unsigned x = 0; x < 16; x++)
      for (int unsigned y = 0; y < 16; y++)
        for (int unsigned z = 0; z < 2; z++)
          op4(x, y, z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
